// File: rtl/regfile_debug_port.sv
// regfile_debug_port: debug burst engine that walks a register file.
// It accepts read or write bursts of up to NREGS beats starting at any register.
// Reads stream out on a valid/ready channel. Writes consume a valid/ready stream
// and drive the register-file write port in the same cycle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/cmd_addr/cmd_count     burst direction, start register, beat count
//   wr_valid/wr_ready/wr_data        write-data stream (WRITE bursts)
//   rd_valid/rd_ready/rd_data/rd_addr read-data stream (READ bursts)
//   rf_A1/rf_RD1                     register-file combinational read port
//   rf_WE3/rf_A3/rf_WD3              register-file write port
//   busy                             FSM not in IDLE
//   abort                            only when REGFILE_DBG_ABORT_EN is defined;
//                                    cancels the active burst
module regfile_debug_port #(
    parameter int NREGS = 32
) (
`ifdef REGFILE_DBG_ABORT_EN
    input  logic        abort,
`endif
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [5:0]  cmd_count,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [4:0]  rd_addr,
    output logic [4:0]  rf_A1,
    input  logic [31:0] rf_RD1,
    output logic        rf_WE3,
    output logic [4:0]  rf_A3,
    output logic [31:0] rf_WD3,
    output logic        busy
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] NREGS_CNT = CW'(NREGS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [CW-1:0] remaining;

    logic          abort_act;
    logic          cmd_fire;
    logic          rd_step;
    logic          wr_step;
    logic          last_beat;
    logic [AW-1:0] next_addr;
    logic [CW-1:0] cmd_beats;

    // Abort only has an effect while a burst is active.
`ifdef REGFILE_DBG_ABORT_EN
    assign abort_act = abort && (state != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    // A pending read beat blocks new commands so the stream never mixes bursts.
    assign cmd_ready = (state == IDLE) && !rd_valid;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_beats = (cmd_count > NREGS_CNT) ? NREGS_CNT : cmd_count;

    assign rd_step   = (state == READ) && (!rd_valid || rd_ready) && !abort_act;
    assign wr_ready  = (state == WRITE);
    assign wr_step   = wr_ready && wr_valid && !abort_act && !reset;

    // x0 beats are consumed but never written.
    assign rf_WE3    = wr_step && (cur_addr != '0);
    assign rf_A3     = wr_step ? cur_addr : '0;
    assign rf_WD3    = wr_step ? wr_data : '0;
    assign rf_A1     = (state == READ) ? cur_addr : '0;
    assign busy      = (state != IDLE);

    assign next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + AW'(1);
    assign last_beat = (remaining == CW'(1));

    // Burst FSM and read-stream output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire && (cmd_beats != '0)) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_beats;
                        state     <= cmd_write ? WRITE : READ;
                    end
                end
                READ: begin
                    if (abort_act) begin
                        remaining <= '0;
                        state     <= IDLE;
                    end else if (rd_step) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining - CW'(1);
                        if (last_beat) state <= IDLE;
                    end
                end
                WRITE: begin
                    if (abort_act) begin
                        remaining <= '0;
                        state     <= IDLE;
                    end else if (wr_step) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining - CW'(1);
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A capture keeps rd_valid high; otherwise a taken beat clears it.
            if (abort_act) begin
                rd_valid <= 1'b0;
            end else if (rd_step) begin
                rd_data  <= rf_RD1;
                rd_addr  <= cur_addr;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
